// File: rtl/tmds_encoder_mc.sv
// Multi-channel TMDS 8b/10b encoder: transition minimisation,
// DC balancing and control-symbol insertion, two-stage pipeline.
module tmds_encoder_mc #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5
) (
  input  logic                    clk_in,
  input  logic                    rst_in_n,
  input  logic                    ce_in,
  input  logic                    ve_in,
  input  logic [NUM_CH*8-1:0]     data_in,
  input  logic [NUM_CH*2-1:0]     ctrl_in,
  output logic [NUM_CH*10-1:0]    tmds_out,
  output logic [NUM_CH*CNT_W-1:0] cnt_out,
  output logic                    valid_out
);

  logic [NUM_CH*9-1:0]     qm_d, qm_q;
  logic                    ve_q;
  logic [NUM_CH*2-1:0]     ctrl_q;
  logic                    v1_q;
  logic [NUM_CH*10-1:0]    tmds_d, tmds_q;
  logic [NUM_CH*CNT_W-1:0] cnt_d, cnt_q;
  logic                    valid_q;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] tm_min(input logic [7:0] d);
    logic [3:0] n;
    logic       xn;
    logic [8:0] m;
    n = ones8(d);
    xn = (n > 4'd4) || (n == 4'd4 && !d[0]);
    m = '0;
    m[0] = d[0];
    for (int i = 1; i < 8; i++)
      m[i] = xn ? ~(d[i] ^ m[i-1]) : (d[i] ^ m[i-1]);
    m[8] = ~xn;
    return m;
  endfunction

  always_comb begin
    qm_d = '0;
    for (int k = 0; k < NUM_CH; k++)
      qm_d[9*k +: 9] = tm_min(data_in[8*k +: 8]);
  end

  always_comb begin
    logic [8:0]              q;
    logic [3:0]              n1;
    logic [9:0]              o;
    logic signed [CNT_W-1:0] c, cn, dis;
    logic                    pos, neg;
    tmds_d = '0;
    cnt_d  = '0;
    q = '0; n1 = '0; o = '0;
    c = '0; cn = '0; dis = '0;
    pos = 1'b0; neg = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      q   = qm_q[9*k +: 9];
      c   = cnt_q[CNT_W*k +: CNT_W];
      n1  = ones8(q[7:0]);
      // ones minus zeros of q_m[7:0]
      dis = CNT_W'({n1, 1'b0}) - CNT_W'(8);
      neg = c[CNT_W-1];
      pos = !neg && (c != '0);
      o   = '0;
      cn  = '0;
      if (!ve_q) begin
        unique case (ctrl_q[2*k +: 2])
          2'b00: o = 10'b1101010100;
          2'b01: o = 10'b0010101011;
          2'b10: o = 10'b0101010100;
          2'b11: o = 10'b1010101011;
        endcase
      end else if (c == '0 || n1 == 4'd4) begin
        o  = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
        cn = q[8] ? c + dis : c - dis;
      end else if ((pos && n1 > 4'd4) || (neg && n1 < 4'd4)) begin
        o  = {1'b1, q[8], ~q[7:0]};
        cn = c - dis + (q[8] ? CNT_W'(2) : CNT_W'(0));
      end else begin
        o  = {1'b0, q[8], q[7:0]};
        cn = c + dis - (q[8] ? CNT_W'(0) : CNT_W'(2));
      end
      tmds_d[10*k +: 10]     = o;
      cnt_d[CNT_W*k +: CNT_W] = cn;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      qm_q    <= '0;
      ve_q    <= 1'b0;
      ctrl_q  <= '0;
      v1_q    <= 1'b0;
      tmds_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (ce_in) begin
      qm_q    <= qm_d;
      ve_q    <= ve_in;
      ctrl_q  <= ctrl_in;
      v1_q    <= 1'b1;
      tmds_q  <= tmds_d;
      cnt_q   <= cnt_d;
      valid_q <= v1_q;
    end
  end

  assign tmds_out  = tmds_q;
  assign cnt_out   = cnt_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Bench for tmds_encoder_mc: directed vector table, reset/hold
// sequences and a random soak against a symbol-level model.
module tb_tmds_encoder_mc;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic ce_in, ve_in;
  logic [NUM_CH*8-1:0]     data_in;
  logic [NUM_CH*2-1:0]     ctrl_in;
  logic [NUM_CH*10-1:0]    tmds_out;
  logic [NUM_CH*CNT_W-1:0] cnt_out;
  logic                    valid_out;

  always #5 clk = ~clk;

  tmds_encoder_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_in(clk), .rst_in_n(rst_n), .ce_in(ce_in), .ve_in(ve_in),
    .data_in(data_in), .ctrl_in(ctrl_in), .tmds_out(tmds_out),
    .cnt_out(cnt_out), .valid_out(valid_out)
  );

  int n_chk = 0;
  int n_fail = 0;

  int         m_cnt [NUM_CH];
  logic [9:0] m_out [NUM_CH];
  logic [7:0] m_byte[NUM_CH];
  logic       m_dat [NUM_CH];
  int         m_en;
  logic                pend_ve;
  logic [NUM_CH*8-1:0] pend_d;
  logic [NUM_CH*2-1:0] pend_c;

  task automatic chk(input string nm, input int ch,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d t=%0t actual=%h required=%h",
               nm, ch, $time, act, exp);
    end
  endtask

  // Transition-minimised word from prefix parity: the XNOR
  // variant is the XOR variant with odd positions inverted.
  function automatic logic [8:0] model_qm(input logic [7:0] d);
    int n;
    logic inv, p;
    logic [8:0] q;
    n = $countones(d);
    inv = (n > 4) || (n == 4 && d[0] == 1'b0);
    p = 1'b0;
    q = '0;
    for (int i = 0; i < 8; i++) begin
      p = p ^ d[i];
      q[i] = p ^ (inv && (i % 2 == 1));
    end
    q[8] = !inv;
    return q;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] w, d;
    w = s[9] ? ~s[7:0] : s[7:0];
    d[0] = w[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return d;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_cnt[ch] = 0; m_out[ch] = '0;
      m_byte[ch] = '0; m_dat[ch] = 1'b0;
    end
    m_en = 0; pend_ve = 1'b0; pend_d = '0; pend_c = '0;
  endtask

  // cnt is the running disparity of the transmitted symbols
  task automatic model_edge();
    logic [8:0] q;
    int n1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_dat[ch] = pend_ve;
      m_byte[ch] = pend_d[8*ch +: 8];
      if (!pend_ve) begin
        case (pend_c[2*ch +: 2])
          2'b00: m_out[ch] = 10'h354;
          2'b01: m_out[ch] = 10'h0AB;
          2'b10: m_out[ch] = 10'h154;
          default: m_out[ch] = 10'h2AB;
        endcase
        m_cnt[ch] = 0;
      end else begin
        q = model_qm(pend_d[8*ch +: 8]);
        n1 = $countones(q[7:0]);
        if (m_cnt[ch] == 0 || n1 == 4)
          m_out[ch] = q[8] ? {2'b01, q[7:0]} : {2'b10, ~q[7:0]};
        else if ((m_cnt[ch] > 0 && n1 > 4) || (m_cnt[ch] < 0 && n1 < 4))
          m_out[ch] = {1'b1, q[8], ~q[7:0]};
        else
          m_out[ch] = {1'b0, q[8], q[7:0]};
        m_cnt[ch] += 2 * $countones(m_out[ch]) - 10;
      end
    end
    pend_ve = ve_in; pend_d = data_in; pend_c = ctrl_in;
    m_en++;
  endtask

  task automatic compare();
    logic signed [CNT_W-1:0] cs;
    int v;
    logic [CNT_W-1:0] ec;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      chk("tmds", ch, 32'(tmds_out[10*ch +: 10]), 32'(m_out[ch]));
      ec = CNT_W'(m_cnt[ch]);
      chk("cnt", ch, 32'(cnt_out[CNT_W*ch +: CNT_W]), 32'(ec));
      cs = cnt_out[CNT_W*ch +: CNT_W];
      v = cs;
      chk("cnt_range", ch, 32'(v >= -10 && v <= 10), 32'd1);
      if (m_dat[ch])
        chk("decode", ch, 32'(decode(tmds_out[10*ch +: 10])),
            32'(m_byte[ch]));
    end
    chk("valid", 0, 32'(valid_out), 32'(m_en >= 2));
  endtask

  task automatic tick(input logic ce, input logic ve,
                      input logic [NUM_CH*8-1:0] d,
                      input logic [NUM_CH*2-1:0] c);
    ce_in = ce; ve_in = ve; data_in = d; ctrl_in = c;
    @(posedge clk);
    if (ce) model_edge();
    @(negedge clk);
    compare();
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    case ($urandom_range(0, 5))
      0: b = 8'h00;
      1: b = 8'hFF;
      2: b = 8'h10;
      default: b = 8'($urandom);
    endcase
    return b;
  endfunction

  task automatic rnd_tick(input int ce_pct);
    logic [NUM_CH*8-1:0] d;
    for (int ch = 0; ch < NUM_CH; ch++) d[8*ch +: 8] = rnd_byte();
    tick($urandom_range(0, 99) < ce_pct, $urandom_range(0, 15) != 0,
         d, NUM_CH*2'($urandom));
  endtask

  typedef struct {
    logic                    ve;
    logic [NUM_CH*8-1:0]     d;
    logic [NUM_CH*2-1:0]     c;
    logic [NUM_CH*10-1:0]    tm;
    logic [NUM_CH*CNT_W-1:0] cn;
  } vec_t;

  vec_t tab[10];
  logic [NUM_CH*10-1:0]    snap_t;
  logic [NUM_CH*CNT_W-1:0] snap_c;
  logic                    snap_v;

  initial begin
    tab[0] = '{1'b0, 24'h0, 6'b000000, {3{10'h354}}, '0};
    tab[1] = '{1'b0, 24'h0, 6'b010101, {3{10'h0AB}}, '0};
    tab[2] = '{1'b0, 24'h0, 6'b101010, {3{10'h154}}, '0};
    tab[3] = '{1'b0, 24'h0, 6'b111111, {3{10'h2AB}}, '0};
    tab[4] = '{1'b1, 24'h000000, 6'b0, {3{10'h100}}, {3{5'h18}}};
    tab[5] = '{1'b1, 24'h000000, 6'b0, {3{10'h3FF}}, {3{5'h02}}};
    tab[6] = '{1'b0, 24'h0, 6'b000000, {3{10'h354}}, '0};
    tab[7] = '{1'b1, 24'h00FF00, 6'b0,
               {10'h100, 10'h200, 10'h100}, {3{5'h18}}};
    tab[8] = '{1'b1, 24'hFFFFFF, 6'b0, {3{10'h0FF}}, {3{5'h1E}}};
    tab[9] = '{1'b0, 24'h0, 6'b000000, {3{10'h354}}, '0};

    rst_n = 1'b0; ce_in = 1'b0; ve_in = 1'b0;
    data_in = '0; ctrl_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tmds", 0, 32'(tmds_out), 32'd0);
    chk("rst_valid", 0, 32'(valid_out), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick(1'b1, tab[i].ve, tab[i].d, tab[i].c);
      if (i > 0) begin
        chk("tab_tmds", i - 1, 32'(tab[i-1].tm), 32'(tmds_out));
        chk("tab_cnt", i - 1, 32'(tab[i-1].cn), 32'(cnt_out));
      end
    end

    repeat (200) rnd_tick(80);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tmds", 0, 32'(tmds_out), 32'd0);
    chk("async_rst_cnt", 0, 32'(cnt_out), 32'd0);
    chk("async_rst_valid", 0, 32'(valid_out), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    repeat (6) tick(1'b1, 1'b1, 24'h00FF10, 6'b0);
    snap_t = tmds_out; snap_c = cnt_out; snap_v = valid_out;
    for (int i = 0; i < 5; i++) begin
      rnd_tick(0);
      chk("hold_tmds", i, 32'(tmds_out), 32'(snap_t));
      chk("hold_cnt", i, 32'(cnt_out), 32'(snap_c));
      chk("hold_valid", i, 32'(valid_out), 32'(snap_v));
    end

    repeat (10000) rnd_tick(75);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_encoder_mc.md
Name: tmds_encoder_mc

Overview:
Parametrised multi-channel TMDS (8b/10b DVI) encoder for the HDMI output path. Per channel: the transition-minimisation stage, then DC balancing with a running-disparity counter, plus control-period symbol insertion. Two-stage pipeline with clock enable, so it can run on a fast clock with a pixel strobe. Sits between the pixel/sync generator and the 10:1 serialisers, one channel per TMDS lane.

Parameters:
NUM_CH, 3, number of TMDS channels (1..4); channel k uses slice k of every packed bus.
CNT_W, 5, width of the signed per-channel disparity counter (min 5).

Ports:
clk_in  input  1  encoder clock
rst_in_n  input  1  asynchronous active-low reset
ce_in  input  1  clock enable / pixel strobe; pipeline advances only when high
ve_in  input  1  video-data enable, shared by all channels; 1 = encode data_in, 0 = control period
data_in  input  NUM_CH*8  pixel bytes; channel k = [8k+7:8k]
ctrl_in  input  NUM_CH*2  control bits {c1,c0}; channel k = [2k+1:2k]
tmds_out  output  NUM_CH*10  encoded symbols; channel k = [10k+9:10k]
cnt_out  output  NUM_CH*CNT_W  signed running disparity per channel (debug/verification)
valid_out  output  1  high once two enabled cycles have passed since reset

Behaviour:
- Reset (rst_in_n low, async): all pipeline registers, tmds_out, cnt_out and valid_out go to 0. Release is synchronous to clk_in.
- ce_in low: every register holds, including counters and outputs. All rules below apply only on enabled edges.
- Latency: 2 enabled cycles, from inputs sampled on edge N to tmds_out updated on edge N+1. valid_out rises on the second enabled edge after reset.
- Stage 1 (per channel, registered along with ve and ctrl):
  - N1 = popcount(d).
  - If N1>4, or N1==4 with d[0]==0: q_m[i] = ~(d[i]^q_m[i-1]) and q_m[8]=0.
  - Otherwise: q_m[i] = d[i]^q_m[i-1] and q_m[8]=1.
  - In both cases q_m[0]=d[0].
- Stage 2, video (registered ve=1). n1 and n0 are the counts of ones and zeros in q_m[7:0], signed arithmetic throughout.
  - If cnt==0 or n1==n0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1-n0) : (n0-n1).
  - Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (n0-n1).
  - Else:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += -2*(~q_m[8]) + (n1-n0).
- Stage 2, control (registered ve=0):
  - cnt is cleared to 0.
  - {c1,c0} maps to out: 00 -> 10'b1101010100, 01 -> 10'b0010101011, 10 -> 10'b0101010100, 11 -> 10'b1010101011.
- Counter range: |cnt| <= 10 by construction, so it never wraps at CNT_W>=5. A bench assertion must flag |cnt|>10.
- Channels are fully independent; they share only ce_in and ve_in.
- ve_in toggling: takes effect per pipeline stage, so the first data symbol after a control period is always encoded from cnt=0.

Test Plan:
- Reset/hold: assert rst_in_n low mid-stream -> tmds_out=0, cnt_out=0 and valid_out=0 immediately, without waiting for a clock edge. With ce_in=0 for 5 cycles -> outputs and counters unchanged.
- Control symbols: ve_in=0, ctrl sweep 00,01,10,11 -> after 2 enabled edges, outputs are 0x354, 0x0AB, 0x154, 0x2AB in that order; cnt_out=0.
- Data 0x00 twice from cnt=0:
  - First symbol -> 0x100, cnt=-8.
  - Second symbol -> 0x3FF, cnt=+2.
- Data 0xFF from cnt=0 -> q_m=0xFF with q_m[8]=0 -> out 0x200, cnt=-8.
- Channel independence: ch0=0x00, ch1=0xFF, ch2=0x00 in one cycle -> 0x100, 0x200, 0x100 in their respective slices.
- Random soak: 10k random bytes with random ve_in/ce_in, checked against a reference model -> bit-exact match; |cnt|<=10; and decoding each symbol returns the original byte.
